// File: rtl/spi_rr_arbiter.sv
// -----------------------------------------------------------------------------
// spi_rr_arbiter
//
// Shares one spi_master between NREQ requesters with round-robin priority.
// Each granted request becomes a single I_valid pulse to the master. The
// master's busy flag is watched for the start and end of the transfer. The
// received word is then returned to the owner together with a one-cycle done
// pulse. If the master never starts within START_TIMEOUT cycles, the
// transaction is closed with an error pulse instead, and O_rdata is left
// untouched.
//
// Every output is a register. A value decided while the FSM sits in a given
// state becomes visible in the following cycle. So O_spi_valid is high in the
// cycle after ISSUE, and O_done/O_err are high in the cycle after DONE.
//
// Parameters
//   NREQ           number of requesters (2..8)
//   DATAWIDTH      SPI word width, equal to the attached spi_master
//   START_TIMEOUT  cycles to wait for master busy before flagging an error
//
// Ports
//   I_clk, I_rst      clock, asynchronous active-high reset
//   I_req             per-requester request level (held until own O_done bit)
//   I_req_data        requester i word at [i*DATAWIDTH +: DATAWIDTH]
//   O_grant           one-hot owner of the running transaction, 0 when idle
//   O_done            one-cycle pulse on the owner's bit at transaction end
//   O_err             one-cycle pulse with O_done when the start timed out
//   O_rdata           last received word, valid while any O_done bit is high
//   O_busy            high whenever a transaction is in flight
//   O_spi_send_data   word to spi_master I_send_data
//   O_spi_valid       one-cycle start pulse to spi_master I_valid
//   I_spi_busy        spi_master O_busy
//   I_spi_recv_data   spi_master O_recv_data
// -----------------------------------------------------------------------------
module spi_rr_arbiter #(
    parameter int NREQ          = 4,
    parameter int DATAWIDTH     = 16,
    parameter int START_TIMEOUT = 4
) (
    input  logic                      I_clk,
    input  logic                      I_rst,
    input  logic [NREQ-1:0]           I_req,
    input  logic [NREQ*DATAWIDTH-1:0] I_req_data,
    output logic [NREQ-1:0]           O_grant,
    output logic [NREQ-1:0]           O_done,
    output logic                      O_err,
    output logic [DATAWIDTH-1:0]      O_rdata,
    output logic                      O_busy,
    output logic [DATAWIDTH-1:0]      O_spi_send_data,
    output logic                      O_spi_valid,
    input  logic                      I_spi_busy,
    input  logic [DATAWIDTH-1:0]      I_spi_recv_data
);

    localparam int              IDXW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0]      TIMEOUT_C  = 8'(START_TIMEOUT);
    localparam logic [IDXW-1:0] LAST_RST_C = IDXW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_C      = NREQ'(1);
    localparam logic [NREQ-1:0] ZERO_C     = {NREQ{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_END   = 3'd3,
        ST_DONE       = 3'd4
    } state_t;

    state_t                state_r,      state_nxt_s;
    logic [NREQ-1:0]       grant_r,      grant_nxt_s;
    logic [NREQ-1:0]       done_r,       done_nxt_s;
    logic                  err_out_r,    err_out_nxt_s;
    logic                  err_flag_r,   err_flag_nxt_s;
    logic [DATAWIDTH-1:0]  rdata_r,      rdata_nxt_s;
    logic                  busy_r,       busy_nxt_s;
    logic [DATAWIDTH-1:0]  send_r,       send_nxt_s;
    logic                  valid_r,      valid_nxt_s;
    logic [7:0]            cnt_r,        cnt_nxt_s;
    logic [IDXW-1:0]       last_r,       last_nxt_s;

    logic [IDXW-1:0]       win_idx_s;
    logic                  win_found_s;

    // Round-robin pick: the scan runs from the farthest candidate back toward
    // last+1, so the last hit is the first requester after the previous owner.
    always_comb begin
        int              idx_v;
        logic [IDXW-1:0] idx_b;
        idx_v       = 0;
        idx_b       = last_r;
        win_idx_s   = last_r;
        win_found_s = 1'b0;
        for (int i = NREQ; i >= 1; i--) begin
            idx_v = (int'(last_r) + i) % NREQ;
            idx_b = IDXW'(idx_v);
            if (I_req[idx_b]) begin
                win_idx_s   = idx_b;
                win_found_s = 1'b1;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_nxt_s    = state_r;
        grant_nxt_s    = grant_r;
        done_nxt_s     = ZERO_C;
        err_out_nxt_s  = 1'b0;
        err_flag_nxt_s = err_flag_r;
        rdata_nxt_s    = rdata_r;
        busy_nxt_s     = busy_r;
        send_nxt_s     = send_r;
        valid_nxt_s    = 1'b0;
        cnt_nxt_s      = cnt_r;
        last_nxt_s     = last_r;

        case (state_r)
            ST_IDLE: begin
                // A master still busy (e.g. after a reset mid-transfer) blocks
                // arbitration, so a new valid never overlaps an old transfer.
                if (win_found_s && !I_spi_busy) begin
                    grant_nxt_s = ONE_C << win_idx_s;
                    last_nxt_s  = win_idx_s;
                    send_nxt_s  = I_req_data[int'(win_idx_s) * DATAWIDTH +: DATAWIDTH];
                    busy_nxt_s  = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                valid_nxt_s = 1'b1;
                cnt_nxt_s   = 8'd0;
                state_nxt_s = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                cnt_nxt_s = cnt_r + 8'd1;
                if (I_spi_busy) begin
                    state_nxt_s = ST_WAIT_END;
                end else if (cnt_r == TIMEOUT_C) begin
                    err_flag_nxt_s = 1'b1;
                    state_nxt_s    = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT_START;
                end
            end
            ST_WAIT_END: begin
                if (!I_spi_busy) begin
                    rdata_nxt_s = I_spi_recv_data;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT_END;
                end
            end
            ST_DONE: begin
                done_nxt_s     = grant_r;
                err_out_nxt_s  = err_flag_r;
                grant_nxt_s    = ZERO_C;
                err_flag_nxt_s = 1'b0;
                busy_nxt_s     = 1'b0;
                state_nxt_s    = ST_IDLE;
            end
            default: begin
                grant_nxt_s    = ZERO_C;
                err_flag_nxt_s = 1'b0;
                busy_nxt_s     = 1'b0;
                state_nxt_s    = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset leaves requester 0 with top priority.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_r    <= ST_IDLE;
            grant_r    <= ZERO_C;
            done_r     <= ZERO_C;
            err_out_r  <= 1'b0;
            err_flag_r <= 1'b0;
            rdata_r    <= {DATAWIDTH{1'b0}};
            busy_r     <= 1'b0;
            send_r     <= {DATAWIDTH{1'b0}};
            valid_r    <= 1'b0;
            cnt_r      <= 8'd0;
            last_r     <= LAST_RST_C;
        end else begin
            state_r    <= state_nxt_s;
            grant_r    <= grant_nxt_s;
            done_r     <= done_nxt_s;
            err_out_r  <= err_out_nxt_s;
            err_flag_r <= err_flag_nxt_s;
            rdata_r    <= rdata_nxt_s;
            busy_r     <= busy_nxt_s;
            send_r     <= send_nxt_s;
            valid_r    <= valid_nxt_s;
            cnt_r      <= cnt_nxt_s;
            last_r     <= last_nxt_s;
        end
    end

    assign O_grant         = grant_r;
    assign O_done          = done_r;
    assign O_err           = err_out_r;
    assign O_rdata         = rdata_r;
    assign O_busy          = busy_r;
    assign O_spi_send_data = send_r;
    assign O_spi_valid     = valid_r;

endmodule

// File: tb/tb_spi_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_rr_arbiter
//
// Directed bench for spi_rr_arbiter (NREQ=4, DATAWIDTH=16, START_TIMEOUT=4).
// A small spi_master model loops the sent word back after a programmable busy
// time, or can be made dead so that it never raises busy. Stimulus pushes the
// expected valid words and done records into queues. A negedge monitor pops
// and compares them whenever the DUT pulses O_spi_valid or O_done.
// -----------------------------------------------------------------------------
module tb_spi_rr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int TO   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic              err;
    logic [DW-1:0]     rdata;
    logic              busy;
    logic [DW-1:0]     spi_send_data;
    logic              spi_valid;

    // master model state
    logic              m_busy = 1'b0;
    logic [DW-1:0]     m_recv = 16'h0000;
    logic [DW-1:0]     m_data = 16'h0000;
    int                m_cnt  = 0;
    int                m_len  = 4;
    bit                m_dead = 1'b0;

    typedef struct {
        logic [NREQ-1:0] done;
        logic            err;
        logic [DW-1:0]   rdata;
        int              lat;    // cycles from valid to done, -1 = not checked
    } exp_done_t;

    logic [DW-1:0] valid_q[$];
    exp_done_t     done_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int grant_cyc = -100;
    int valid_cyc = -100;
    logic [NREQ-1:0] prev_grant = 4'b0000;

    spi_rr_arbiter #(
        .NREQ          (NREQ),
        .DATAWIDTH     (DW),
        .START_TIMEOUT (TO)
    ) dut (
        .I_clk           (clk),
        .I_rst           (rst),
        .I_req           (req),
        .I_req_data      (req_data),
        .O_grant         (grant),
        .O_done          (done),
        .O_err           (err),
        .O_rdata         (rdata),
        .O_busy          (busy),
        .O_spi_send_data (spi_send_data),
        .O_spi_valid     (spi_valid),
        .I_spi_busy      (m_busy),
        .I_spi_recv_data (m_recv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_msg(input string name, input string got, input string want);
        checks++;
        errors++;
        $display("FAIL %s: got %s expected %s (cycle %0d)", name, got, want, cyc);
    endtask

    // spi_master model: one transfer per valid, busy for m_len cycles, loopback.
    always @(posedge clk) begin
        if (m_busy) begin
            if (m_cnt == 0) begin
                m_busy <= 1'b0;
                m_recv <= m_data;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (spi_valid && !m_dead) begin
            m_busy <= 1'b1;
            m_data <= spi_send_data;
            m_cnt  <= m_len - 1;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_done_t e;
        logic [DW-1:0] ev;
        if (grant != 4'b0000 && prev_grant == 4'b0000) grant_cyc <= cyc;
        prev_grant <= grant;
        chk("grant_onehot", 32'($onehot0(grant)), 32'd1);
        chk("err_without_done", 32'(err && (done == 4'b0000)), 32'd0);
        if (spi_valid) begin
            valid_cyc <= cyc;
            chk("valid_after_grant", 32'(cyc - grant_cyc), 32'd1);
            chk("valid_while_master_busy", 32'(m_busy), 32'd0);
            if (valid_q.size() == 0) begin
                fail_msg("unexpected_valid", $sformatf("valid data %h", spi_send_data), "no transfer");
            end else begin
                ev = valid_q.pop_front();
                chk("send_data", 32'(spi_send_data), 32'(ev));
            end
        end
        if (done != 4'b0000) begin
            if (done_q.size() == 0) begin
                fail_msg("unexpected_done", $sformatf("done %b", done), "no done");
            end else begin
                e = done_q.pop_front();
                chk("done_vec", 32'(done), 32'(e.done));
                chk("done_err", 32'(err), 32'(e.err));
                chk("done_rdata", 32'(rdata), 32'(e.rdata));
                if (e.lat >= 0) chk("done_latency", 32'(cyc - valid_cyc), 32'(e.lat));
            end
        end
    end

    task automatic push_exp(input logic [DW-1:0] vdata, input logic [NREQ-1:0] dvec,
                            input logic e_err, input logic [DW-1:0] e_rdata, input int lat);
        exp_done_t e;
        valid_q.push_back(vdata);
        e.done  = dvec;
        e.err   = e_err;
        e.rdata = e_rdata;
        e.lat   = lat;
        done_q.push_back(e);
    endtask

    task automatic wait_done(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] drop, input string nm);
        int n = 0;
        bit got = 1'b0;
        while (!got && n < 300) begin
            @(negedge clk);
            n++;
            if ((done & mask) != 4'b0000) got = 1'b1;
        end
        if (!got) fail_msg(nm, "no done within 300 cycles", $sformatf("done %b", mask));
        req = req & ~drop;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        bit got = 1'b0;
        while (!got && n < 300) begin
            @(negedge clk);
            n++;
            if (spi_valid) got = 1'b1;
        end
        if (!got) fail_msg(nm, "no valid within 300 cycles", "valid pulse");
    endtask

    task automatic wait_mbusy(input string nm);
        int n = 0;
        bit got = 1'b0;
        while (!got && n < 300) begin
            @(negedge clk);
            n++;
            if (m_busy) got = 1'b1;
        end
        if (!got) fail_msg(nm, "master never busy", "master busy");
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_grant"}, 32'(grant), 32'd0);
        chk({pfx, "_done"}, 32'(done), 32'd0);
        chk({pfx, "_err"}, 32'(err), 32'd0);
        chk({pfx, "_rdata"}, 32'(rdata), 32'd0);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_send_data"}, 32'(spi_send_data), 32'd0);
        chk({pfx, "_valid"}, 32'(spi_valid), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        req      = 4'b0000;
        req_data = {16'hD003, 16'hC002, 16'hB001, 16'hA000};
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // single request from requester 2
        req_data[2*DW +: DW] = 16'hAA55;
        push_exp(16'hAA55, 4'b0100, 1'b0, 16'hAA55, -1);
        req = 4'b0100;
        wait_done(4'b0100, 4'b0100, "single_done_timeout");
        req_data[2*DW +: DW] = 16'hC002;
        repeat (5) @(negedge clk);
        chk("single_idle_after", 32'(grant), 32'd0);

        // contention: all four held from reset, order 0,1,2,3,0
        req = 4'b1111;
        rst = 1'b1;
        push_exp(16'hA000, 4'b0001, 1'b0, 16'hA000, -1);
        push_exp(16'hB001, 4'b0010, 1'b0, 16'hB001, -1);
        push_exp(16'hC002, 4'b0100, 1'b0, 16'hC002, -1);
        push_exp(16'hD003, 4'b1000, 1'b0, 16'hD003, -1);
        push_exp(16'hA000, 4'b0001, 1'b0, 16'hA000, -1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_done(4'b0001, 4'b0000, "cont0_timeout");
        wait_done(4'b0010, 4'b0000, "cont1_timeout");
        wait_done(4'b0100, 4'b0000, "cont2_timeout");
        wait_done(4'b1000, 4'b0000, "cont3_timeout");
        wait_done(4'b0001, 4'b1111, "cont4_timeout");
        repeat (5) @(negedge clk);
        chk("contention_idle_after", 32'(busy), 32'd0);

        // fairness: req0 held, req3 pulsed in during a req0 transfer
        push_exp(16'hA000, 4'b0001, 1'b0, 16'hA000, -1);
        push_exp(16'hD003, 4'b1000, 1'b0, 16'hD003, -1);
        push_exp(16'hA000, 4'b0001, 1'b0, 16'hA000, -1);
        req = 4'b0001;
        wait_valid("fair_valid_timeout");
        req[3] = 1'b1;
        wait_done(4'b0001, 4'b0000, "fair0_timeout");
        wait_done(4'b1000, 4'b1000, "fair3_timeout");
        wait_done(4'b0001, 4'b0001, "fair0b_timeout");
        repeat (3) @(negedge clk);

        // start timeout: master never goes busy, rdata keeps previous word
        m_dead = 1'b1;
        push_exp(16'hB001, 4'b0010, 1'b1, 16'hA000, TO + 2);
        req = 4'b0010;
        wait_done(4'b0010, 4'b0010, "timeout_done_timeout");
        m_dead = 1'b0;
        repeat (3) @(negedge clk);

        // request drop during WAIT_END still completes, no re-grant
        m_len = 6;
        push_exp(16'hB001, 4'b0010, 1'b0, 16'hB001, -1);
        req = 4'b0010;
        wait_mbusy("drop_mbusy_timeout");
        repeat (2) @(negedge clk);
        req = 4'b0000;
        wait_done(4'b0010, 4'b0000, "drop_done_timeout");
        repeat (6) @(negedge clk);
        chk("drop_no_regrant", 32'(busy), 32'd0);

        // asynchronous reset during WAIT_END with the master busy ~10 more cycles
        m_len = 14;
        valid_q.push_back(16'hC002);
        req = 4'b0100;
        wait_mbusy("rstmid_mbusy_timeout");
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        req = 4'b0001;
        #1;
        chk_all_zero("rstmid");
        chk("rstmid_master_still_busy", 32'(m_busy), 32'd1);
        m_len = 4;
        push_exp(16'hA000, 4'b0001, 1'b0, 16'hA000, -1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_done(4'b0001, 4'b0001, "rstmid_done_timeout");
        repeat (5) @(negedge clk);

        chk("valid_queue_empty", 32'(valid_q.size()), 32'd0);
        chk("done_queue_empty", 32'(done_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
